// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the operand-issue stage and its companion alu.
// Opcode values, data/address widths and the shift helper used by the alu.
package alu_issue_stage_pkg;

    localparam int REG_W  = 16;
    localparam int REGA_W = 3;

    localparam logic [2:0] OP_SHIFT = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_AND   = 3'b101;
    localparam logic [2:0] OP_OR    = 3'b110;
    localparam logic [2:0] OP_NOT   = 3'b111;

    // A negative op2 (bit 15 set) shifts right by its magnitude.
    // Any magnitude of 16 or more yields zero.
    function automatic logic [REG_W-1:0] alu_shift(input logic [REG_W-1:0] a,
                                                   input logic [REG_W-1:0] b);
        logic [REG_W-1:0] amt;
        amt = b[REG_W-1] ? (~b + 16'd1) : b;
        if (amt >= 16'd16)
            return '0;
        else if (b[REG_W-1])
            return a >> amt[3:0];
        else
            return a << amt[3:0];
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-side handshake, alu operand/result and write-back bus of the issue stage.
// The slave modport is the stage itself; the master is the upstream/alu side.
interface alu_issue_stage_if;
    import alu_issue_stage_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [REGA_W-1:0] in_rd;
    logic [REGA_W-1:0] in_rs1;
    logic [REGA_W-1:0] in_rs2;
    logic              in_use_imm;
    logic [REG_W-1:0]  in_imm;
    logic [REG_W-1:0]  alu_op1;
    logic [REG_W-1:0]  alu_op2;
    logic [2:0]        alu_operation;
    logic [REG_W-1:0]  alu_result;
    logic              wb_valid;
    logic [REGA_W-1:0] wb_rd;
    logic [REG_W-1:0]  wb_data;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, alu_result,
        output in_ready, alu_op1, alu_op2, alu_operation, wb_valid, wb_rd, wb_data
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, alu_result,
        input  in_ready, alu_op1, alu_op2, alu_operation, wb_valid, wb_rd, wb_data
    );

endinterface

// File: rtl/alu_issue_stage_alu.sv
// Combinational alu fed by the registered operands of alu_issue_stage.
// Unassigned opcodes produce zero.
module alu
    import alu_issue_stage_pkg::*;
(
    input  logic [REG_W-1:0] op1,
    input  logic [REG_W-1:0] op2,
    input  logic [2:0]       operation,
    output logic [REG_W-1:0] result
);

    always_comb begin
        result = '0;
        case (operation)
            OP_SHIFT: result = alu_shift(op1, op2);
            OP_ADD:   result = op1 + op2;
            OP_AND:   result = op1 & op2;
            OP_OR:    result = op1 | op2;
            OP_NOT:   result = ~op1;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage_reg_file_2r1w.sv
// Register file with two asynchronous read ports and one synchronous write port.
// Entry 0 has no storage and always reads as zero.
module reg_file_2r1w
    import alu_issue_stage_pkg::*;
#(
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [REG_W-1:0] rdata1,
    output logic [REG_W-1:0] rdata2,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [REG_W-1:0] wdata
);

    logic [REG_W-1:0] regs [NREGS];

    assign regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [REG_W-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (!reset_n)
                    q_reg <= '0;
                else if (we && (waddr == AW'(gi)))
                    q_reg <= wdata;
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage ISSUE -> EX/WB operand-issue stage in front of an external alu.
// Holds a read-after-write interlock (no bypass) and retire/stall counters.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_issue_stage_if.slave bus,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic              ex_valid_reg;
    logic [REGA_W-1:0] ex_rd_reg;
    logic [REG_W-1:0]  op1_reg, op2_reg;
    logic [2:0]        operation_reg;
    logic              wb_valid_reg;
    logic [REGA_W-1:0] wb_rd_reg;
    logic [REG_W-1:0]  wb_data_reg;
    logic [CNT_W-1:0]  retire_cnt_reg, stall_cnt_reg;
    logic [REG_W-1:0]  rs1_data, rs2_data;
    logic              hazard, accept;

    reg_file_2r1w #(.NREGS(NREGS)) u_rf (
        .clk    (clk),
        .reset_n(reset_n),
        .raddr1 (bus.in_rs1[AW-1:0]),
        .raddr2 (bus.in_rs2[AW-1:0]),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .we     (ex_valid_reg),
        .waddr  (ex_rd_reg[AW-1:0]),
        .wdata  (bus.alu_result)
    );

    // NOT ignores op2, so a busy rs2 does not block it; r0 is never a hazard.
    assign hazard = ex_valid_reg && (ex_rd_reg != '0) &&
                    ((bus.in_rs1 == ex_rd_reg) ||
                     (!bus.in_use_imm && (bus.in_op != OP_NOT) && (bus.in_rs2 == ex_rd_reg)));
    assign accept = bus.in_valid && !hazard;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_valid_reg   <= 1'b0;
            ex_rd_reg      <= '0;
            op1_reg        <= '0;
            op2_reg        <= '0;
            operation_reg  <= '0;
            wb_valid_reg   <= 1'b0;
            wb_rd_reg      <= '0;
            wb_data_reg    <= '0;
            retire_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            ex_valid_reg <= accept;
            if (accept) begin
                ex_rd_reg     <= bus.in_rd;
                op1_reg       <= rs1_data;
                op2_reg       <= bus.in_use_imm ? bus.in_imm : rs2_data;
                operation_reg <= bus.in_op;
            end
            wb_valid_reg <= ex_valid_reg;
            if (ex_valid_reg) begin
                wb_rd_reg      <= ex_rd_reg;
                wb_data_reg    <= bus.alu_result;
                retire_cnt_reg <= retire_cnt_reg + 1'b1;
            end
            if (bus.in_valid && hazard)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign bus.in_ready      = !hazard;
    assign bus.alu_op1       = op1_reg;
    assign bus.alu_op2       = op2_reg;
    assign bus.alu_operation = operation_reg;
    assign bus.wb_valid      = wb_valid_reg;
    assign bus.wb_rd         = wb_rd_reg;
    assign bus.wb_data       = wb_data_reg;
    assign retire_cnt        = retire_cnt_reg;
    assign stall_cnt         = stall_cnt_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Table-driven bench for alu_issue_stage with the alu alongside; write-backs are
// checked against a scoreboard of expected {rd, data, accept cycle} records.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        use_imm;
        logic [15:0] imm;
        logic [15:0] exp_data;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] retire_cnt, stall_cnt;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    sb_t         sb[$];
    vec_t        tbl[17];

    alu_issue_stage_if bus ();

    alu_issue_stage #(.NREGS(8), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .retire_cnt(retire_cnt),
        .stall_cnt (stall_cnt)
    );

    alu u_alu (
        .op1      (bus.alu_op1),
        .op2      (bus.alu_op2),
        .operation(bus.alu_operation),
        .result   (bus.alu_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.wb_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected no write-back",
                         bus.wb_rd, bus.wb_data);
            end else begin
                sb_t e;
                e = sb.pop_front();
                $display("wb rd=%0d data=0x%04h cyc=%0d", bus.wb_rd, bus.wb_data, cyc);
                check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                check("wb_data", 32'(bus.wb_data), 32'(e.data));
                check("wb_latency", 32'(cyc), 32'(e.cyc + 2));
            end
        end
    end

    // Entered and left at a falling edge; holds the instruction until accepted.
    task automatic issue(input vec_t v);
        int  stalls;
        int  k;
        bit  acc;
        bus.in_valid   = 1'b1;
        bus.in_op      = v.op;
        bus.in_rd      = v.rd;
        bus.in_rs1     = v.rs1;
        bus.in_rs2     = v.rs2;
        bus.in_use_imm = v.use_imm;
        bus.in_imm     = v.imm;
        stalls = 0;
        acc = 1'b0;
        k = 0;
        while (!acc && stalls < 8) begin
            #1;
            k = cyc;
            acc = bus.in_ready;
            if (!acc) stalls++;
            @(posedge clk);
            if (acc) sb.push_back('{v.rd, v.exp_data, k});
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        $display("issue op=%03b rd=%0d rs1=%0d rs2=%0d imm=%0d/0x%04h stalls=%0d",
                 v.op, v.rd, v.rs1, v.rs2, v.use_imm, v.imm, stalls);
        check("accepted", 32'(acc), 32'd1);
        check("stall_cycles", 32'(stalls), 32'(v.exp_stall));
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{OP_ADD,   3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 16'h0005, 0};
        tbl[1]  = '{OP_ADD,   3'd2, 3'd1, 3'd0, 1'b1, 16'h0003, 16'h0008, 1};
        tbl[2]  = '{OP_ADD,   3'd3, 3'd0, 3'd0, 1'b1, 16'h8001, 16'h8001, 0};
        tbl[3]  = '{OP_SHIFT, 3'd5, 3'd3, 3'd0, 1'b1, 16'hFFFF, 16'h4000, 1};
        tbl[4]  = '{OP_SHIFT, 3'd6, 3'd3, 3'd0, 1'b1, 16'h0004, 16'h0010, 0};
        tbl[5]  = '{OP_SHIFT, 3'd7, 3'd3, 3'd0, 1'b1, 16'h0010, 16'h0000, 0};
        tbl[6]  = '{OP_ADD,   3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 16'hFFFF, 0};
        tbl[7]  = '{OP_ADD,   3'd1, 3'd1, 3'd0, 1'b1, 16'h0002, 16'h0001, 1};
        tbl[8]  = '{OP_ADD,   3'd4, 3'd0, 3'd0, 1'b1, 16'h0077, 16'h0077, 0};
        tbl[9]  = '{OP_NOT,   3'd2, 3'd0, 3'd4, 1'b0, 16'h0000, 16'hFFFF, 0};
        tbl[10] = '{OP_AND,   3'd3, 3'd2, 3'd4, 1'b0, 16'h0000, 16'h0077, 1};
        tbl[11] = '{OP_OR,    3'd5, 3'd1, 3'd4, 1'b0, 16'h0000, 16'h0077, 0};
        tbl[12] = '{OP_ADD,   3'd0, 3'd0, 3'd0, 1'b1, 16'h1234, 16'h1234, 0};
        tbl[13] = '{OP_ADD,   3'd6, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000, 0};
        tbl[14] = '{3'b001,   3'd7, 3'd1, 3'd0, 1'b1, 16'h0009, 16'h0000, 0};
        tbl[15] = '{OP_ADD,   3'd2, 3'd4, 3'd5, 1'b0, 16'h0000, 16'h00EE, 0};
        tbl[16] = '{OP_ADD,   3'd3, 3'd2, 3'd0, 1'b1, 16'hFF20, 16'h000E, 1};

        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_use_imm = 1'b0; bus.in_imm = '0;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_alu_op1", 32'(bus.alu_op1), 32'd0);
        check("rst_retire", 32'(retire_cnt), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 17; i++) issue(tbl[i]);

        repeat (3) @(negedge clk);
        check("retire_cnt", 32'(retire_cnt), 32'd17);
        check("stall_cnt", 32'(stall_cnt), 32'd5);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Reset while an instruction sits in EX: it must not be written.
        v = '{OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0055, 16'h0055, 0};
        issue(v);
        reset_n = 1'b0;
        @(negedge clk);
        sb.delete();
        check("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("mid_rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        check("mid_rst_wb_data", 32'(bus.wb_data), 32'd0);
        check("mid_rst_alu_op2", 32'(bus.alu_op2), 32'd0);
        check("mid_rst_alu_operation", 32'(bus.alu_operation), 32'd0);
        check("mid_rst_retire", 32'(retire_cnt), 32'd0);
        check("mid_rst_stall", 32'(stall_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_wb_valid", 32'(bus.wb_valid), 32'd0);

        for (int k = 1; k < 8; k++) begin
            v = '{OP_ADD, 3'd0, 3'(k), 3'd0, 1'b0, 16'h0000, 16'h0000, 0};
            issue(v);
        end
        repeat (3) @(negedge clk);
        check("post_rst_retire", 32'(retire_cnt), 32'd7);
        check("post_rst_sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within 200000 time units");
        $fatal(1);
    end

endmodule
